// File: rtl/lmsm_sequencer.sv
// lmsm_sequencer: walks an 8-bit register mask lowest-bit first.
// Each selected register gets one (register, address) transfer for load-multiple or store-multiple.
module lmsm_sequencer #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              proc_rst,
  input  logic              start,
  input  logic              is_store,
  input  logic [7:0]        reg_mask,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              step,
  output logic              busy,
  output logic              valid,
  output logic [2:0]        reg_idx,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              rf_write,
  output logic              mem_write,
  output logic [3:0]        xfer_count,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, SCAN, XFER, DONE} state_t;

  state_t            state_q, state_d;
  logic [7:0]        mask_q, mask_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              store_q, store_d;
  logic [3:0]        count_q, count_d;
  logic [2:0]        idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        low;

  always_comb begin
    low = '0;
    for (int i = 7; i >= 0; i--) if (mask_q[i]) low = 3'(i);
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    base_d  = base_q;
    store_d = store_q;
    count_d = count_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = SCAN;
        mask_d  = reg_mask;
        base_d  = base_addr;
        store_d = is_store;
        count_d = '0;
      end
      SCAN: if (mask_q == '0) state_d = DONE;
      else begin
        state_d = XFER;
        idx_d   = low;
        addr_d  = base_q + ADDR_W'(count_q);
      end
      XFER: if (step) begin
        state_d = SCAN;
        mask_d  = mask_q & ~(8'd1 << idx_q);
        count_d = count_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge proc_rst) begin
    if (!proc_rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      base_q  <= '0;
      store_q <= 1'b0;
      count_q <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      base_q  <= base_d;
      store_q <= store_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
    end
  end

  assign busy       = state_q != IDLE;
  assign valid      = state_q == XFER;
  assign done       = state_q == DONE;
  assign reg_idx    = idx_q;
  assign mem_addr   = addr_q;
  assign xfer_count = count_q;
  assign rf_write   = valid & step & ~store_q;
  assign mem_write  = valid & step & store_q;
endmodule
